// File: rtl/display_pkg.sv
// Shared display definitions for the countdown sequencer and segment_display.
// - state_t            : countdown sequencer state encoding (2-bit)
// - SECONDS_ACTIVE_BIT : bit of the seconds word that carries the active flag
// - BCD_MAX_NIBBLE     : largest legal BCD digit
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int unsigned SECONDS_ACTIVE_BIT = 8;
  localparam logic [3:0]  BCD_MAX_NIBBLE     = 4'd9;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between the menu logic and the countdown sequencer.
// - start, load_bcd, pause, cancel : commands from the menu side
// - seconds, busy, expired, load_err : status back from the sequencer
// Modports: master = menu side (drives commands), slave = countdown_ctrl.
interface countdown_ctrl_if;
  logic       start;
  logic [7:0] load_bcd;
  logic       pause;
  logic       cancel;
  logic [8:0] seconds;
  logic       busy;
  logic       expired;
  logic       load_err;

  modport master (
    output start, load_bcd, pause, cancel,
    input  seconds, busy, expired, load_err
  );

  modport slave (
    input  start, load_bcd, pause, cancel,
    output seconds, busy, expired, load_err
  );
endinterface

// File: rtl/countdown_ctrl_prescaler.sv
// One-second prescaler for the countdown sequencer.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   clr   : synchronous clear of the cycle counter (wins over en)
//   en    : count enable; the counter holds its value while low
//   tick  : high for one cycle when an enabled counter sits at TICKS_PER_SEC-1
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned PRESC_W       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PRESC_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer producing the 9-bit seconds word for segment_display.
// Loads a two-digit BCD value, decrements it once per second, supports
// pause and cancel, pulses expired on reaching 00 and then holds "00" for
// HOLD_SECS seconds.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : countdown_ctrl_if.slave
//           start/load_bcd : one-cycle load-and-run request, {tens, ones} BCD
//           pause          : level, freezes the countdown in RUN
//           cancel         : one-cycle abort to IDLE
//           seconds        : {active, tens, ones}
//           busy           : high in RUN, PAUSED or HOLD
//           expired        : one-cycle pulse when the count reaches 00
//           load_err       : one-cycle pulse when a start is rejected
module countdown_ctrl
  import display_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned HOLD_SECS     = 1,
  parameter int unsigned PRESC_W       = 27
) (
  input  logic              clk,
  input  logic              reset,
  countdown_ctrl_if.slave   bus
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_SECS - 1);

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] hold_q, hold_d;
  logic       expired_q, expired_d;
  logic       load_err_q, load_err_d;

  logic       load_ok;
  logic       load_go;
  logic       presc_clr;
  logic       presc_en;
  logic       tick;
  logic [7:0] count_dec;

  assign load_ok = (bus.load_bcd[7:4] <= BCD_MAX_NIBBLE) &&
                   (bus.load_bcd[3:0] <= BCD_MAX_NIBBLE);
  assign load_go = bus.start && load_ok;

  // Prescaler control is derived from inputs and state only, so tick never
  // feeds back into its own enable. PAUSED with pause low counts like RUN,
  // which makes the frozen interval exactly as long as pause is held.
  // A rejected start freezes everything for that cycle.
  always_comb begin
    presc_clr = bus.cancel || load_go;
    presc_en  = 1'b0;
    if (!bus.cancel && !bus.start) begin
      unique case (state_q)
        S_RUN, S_PAUSED: presc_en = !bus.pause;
        S_HOLD:          presc_en = (HOLD_SECS != 0);
        default:         presc_en = 1'b0;
      endcase
    end
  end

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PRESC_W       (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  // BCD decrement with borrow from tens into ones.
  always_comb begin
    if (count_q[3:0] == 4'd0) begin
      count_dec = {count_q[7:4] - 4'd1, BCD_MAX_NIBBLE};
    end else begin
      count_dec = {count_q[7:4], count_q[3:0] - 4'd1};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hold_d     = hold_q;
    expired_d  = 1'b0;
    load_err_d = 1'b0;

    if (bus.cancel) begin
      state_d = S_IDLE;
      count_d = '0;
      hold_d  = '0;
    end else if (bus.start && !load_ok) begin
      load_err_d = 1'b1;
    end else if (bus.start) begin
      count_d = bus.load_bcd;
      hold_d  = '0;
      if (bus.load_bcd == 8'h00) begin
        state_d   = S_HOLD;
        expired_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_RUN, S_PAUSED: begin
          if (bus.pause) begin
            state_d = S_PAUSED;
          end else begin
            state_d = S_RUN;
            if (tick && count_q != 8'h00) begin
              count_d = count_dec;
              if (count_dec == 8'h00) begin
                state_d   = S_HOLD;
                expired_d = 1'b1;
                hold_d    = '0;
              end
            end
          end
        end
        S_HOLD: begin
          if (HOLD_SECS == 0) begin
            state_d = S_IDLE;
          end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_IDLE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      hold_q     <= '0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.seconds[SECONDS_ACTIVE_BIT] = (state_q != S_IDLE);
  assign bus.seconds[7:0]                = count_q;
  assign bus.busy                        = (state_q != S_IDLE);
  assign bus.expired                     = expired_q;
  assign bus.load_err                    = load_err_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  typedef struct packed {
    logic [8:0] sec;
    logic       busy;
    logic       exp;
    logic       lerr;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  obs_t exp_q[$];

  countdown_ctrl_if cif ();

  countdown_ctrl #(
    .TICKS_PER_SEC (4),
    .HOLD_SECS     (1),
    .PRESC_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected timelines: n consecutive cycles of the same observation.
  task automatic push(input int n, input logic [8:0] sec, input logic e, input logic le);
    obs_t o;
    o.sec  = sec;
    o.busy = sec[8];
    o.exp  = e;
    o.lerr = le;
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.sec  = cif.seconds;
    o.busy = cif.busy;
    o.exp  = cif.expired;
    o.lerr = cif.load_err;
    return o;
  endfunction

  task automatic idle_inputs();
    cif.start    = 1'b0;
    cif.cancel   = 1'b0;
    cif.pause    = 1'b0;
    cif.load_bcd = 8'h00;
  endtask

  task automatic test_reset();
    obs_t got, want;
    exp_q.delete();
    push(22, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      idle_inputs();
      reset = (k > 2);
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  task automatic test_countdown();
    obs_t got, want;
    exp_q.delete();
    push(4, 9'h112, 1'b0, 1'b0);
    push(4, 9'h111, 1'b0, 1'b0);
    push(4, 9'h110, 1'b0, 1'b0);
    push(4, 9'h109, 1'b0, 1'b0);
    push(3, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      idle_inputs();
      if (k == 1)  begin cif.start = 1'b1; cif.load_bcd = 8'h12; end
      if (k == 17) cif.cancel = 1'b1;
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL countdown cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  task automatic test_expire();
    obs_t got, want;
    exp_q.delete();
    push(4, 9'h102, 1'b0, 1'b0);
    push(4, 9'h101, 1'b0, 1'b0);
    push(1, 9'h100, 1'b1, 1'b0);
    push(3, 9'h100, 1'b0, 1'b0);
    push(4, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h02; end
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL expire cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  // pause high for cycles 7..16: every timing point after it shifts by 10.
  task automatic test_pause();
    obs_t got, want;
    exp_q.delete();
    push(4,  9'h105, 1'b0, 1'b0);
    push(14, 9'h104, 1'b0, 1'b0);
    push(4,  9'h103, 1'b0, 1'b0);
    push(4,  9'h102, 1'b0, 1'b0);
    push(4,  9'h101, 1'b0, 1'b0);
    push(1,  9'h100, 1'b1, 1'b0);
    push(3,  9'h100, 1'b0, 1'b0);
    push(2,  9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h05; end
      cif.pause = (k >= 7 && k <= 16);
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL pause cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  task automatic test_load_err();
    obs_t got, want;
    exp_q.delete();
    push(1, 9'h000, 1'b0, 1'b1);
    push(1, 9'h000, 1'b0, 1'b0);
    push(2, 9'h112, 1'b0, 1'b0);
    push(1, 9'h112, 1'b0, 1'b1);
    push(2, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h3A; end
      if (k == 3) begin cif.start = 1'b1; cif.load_bcd = 8'h12; end
      if (k == 5) begin cif.start = 1'b1; cif.load_bcd = 8'hA1; end
      if (k == 6) cif.cancel = 1'b1;
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load_err cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  task automatic test_start_cancel();
    obs_t got, want;
    exp_q.delete();
    push(3, 9'h112, 1'b0, 1'b0);
    push(6, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h12; end
      if (k == 4) begin cif.start = 1'b1; cif.cancel = 1'b1; cif.load_bcd = 8'h05; end
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL start_cancel cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    exp_q.delete();
    push(4, 9'h108, 1'b0, 1'b0);
    push(1, 9'h107, 1'b0, 1'b0);
    push(7, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h08; end
      reset = !(k == 6 || k == 7);
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_zero();
    obs_t got, want;
    exp_q.delete();
    push(1, 9'h100, 1'b1, 1'b0);
    push(3, 9'h100, 1'b0, 1'b0);
    push(3, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h00; end
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL zero cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  // A second start mid-run reloads the count and restarts the prescaler.
  task automatic test_back_to_back();
    obs_t got, want;
    exp_q.delete();
    push(2, 9'h112, 1'b0, 1'b0);
    push(4, 9'h105, 1'b0, 1'b0);
    push(2, 9'h104, 1'b0, 1'b0);
    push(2, 9'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle_inputs();
      if (k == 1) begin cif.start = 1'b1; cif.load_bcd = 8'h12; end
      if (k == 3) begin cif.start = 1'b1; cif.load_bcd = 8'h05; end
      if (k == 9) cif.cancel = 1'b1;
      @(posedge clk); #1;
      got  = observe();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", k,
                 got.sec, got.busy, got.exp, got.lerr, want.sec, want.busy, want.exp, want.lerr);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_countdown();
    test_expire();
    test_pause();
    test_load_err();
    test_start_cancel();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
